// File: rtl/wb_pkg.sv
// Shared Wishbone constants and arbiter state encoding.
package wb_pkg;
  localparam int ADR_MSB = 11;
  localparam int ADR_LSB = 2;
  localparam int DW      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } wb_state_e;

  // One-hot grant vector seen outside the arbiter; 00 when idle.
  function automatic logic [1:0] state_to_gnt(wb_state_e s);
    case (s)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/wb_timeout_cnt.sv
// Slave wait counter: counts unanswered strobe cycles and flags a timeout
// on the TIMEOUT-th one. A slave ack/err in that same cycle suppresses it.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic idle,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic timeout
);
  logic [7:0] cnt_q;

  assign timeout = stb && !ack && !err && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (idle || !stb || ack || err || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with a registered grant and a
// slave-wait timeout that terminates a hung cycle with an error.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [ADR_MSB:ADR_LSB] m0_adr_i,
  input  logic [3:0]             m0_sel_i,
  input  logic [DW-1:0]          m0_dat_i,
  output logic [DW-1:0]          m0_dat_o,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [ADR_MSB:ADR_LSB] m1_adr_i,
  input  logic [3:0]             m1_sel_i,
  input  logic [DW-1:0]          m1_dat_i,
  output logic [DW-1:0]          m1_dat_o,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [ADR_MSB:ADR_LSB] s_adr_o,
  output logic [3:0]             s_sel_o,
  output logic [DW-1:0]          s_dat_o,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [1:0]             gnt_o
);
  // Handshake: a beat completes in the cycle where stb=1 and ack or err=1;
  // cyc framing the beats belongs to one master until that master drops it.
  wb_state_e state_q, state_d;
  logic      last_gnt_q, last_gnt_d;
  logic      stb_raw, timeout, sel0, sel1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        // On a tie, the master that did not hold the last grant wins.
        if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel0  = (state_q == GNT0);
  assign sel1  = (state_q == GNT1);
  assign gnt_o = state_to_gnt(state_q);

  always_comb begin
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (sel0) begin
      s_cyc_o = m0_cyc_i;
      stb_raw = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (sel1) begin
      s_cyc_o = m1_cyc_i;
      stb_raw = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .idle    (state_q == IDLE),
    .stb     (stb_raw),
    .ack     (s_ack_i),
    .err     (s_err_i),
    .timeout (timeout)
  );

  assign s_stb_o  = stb_raw && !timeout;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  // err dominates ack when a slave raises both.
  assign m0_ack_o = sel0 && s_ack_i && !s_err_i;
  assign m1_ack_o = sel1 && s_ack_i && !s_err_i;
  assign m0_err_o = sel0 && (s_err_i || timeout);
  assign m1_err_o = sel1 && (s_err_i || timeout);
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a per-cycle vector table for arbitration
// and response routing, plus sequences for reads, round robin, timeout, reset.
module tb_wb_rr_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [11:2] m0_adr_i, m1_adr_i, s_adr_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       m0c, m1c, ack, err;
    logic [1:0] exp_gnt;
    logic       e0a, e0e, e1a, e1e, e_cyc;
    logic [9:0] e_adr;
  } vec_t;
  vec_t tbl[10];

  always #5 HCLK = ~HCLK;

  wb_rr_arbiter #(.TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input logic c0, input logic c1);
    m0_cyc_i = c0; m0_stb_i = c0;
    m1_cyc_i = c1; m1_stb_i = c1;
  endtask

  task automatic clear_inputs();
    set_m(1'b0, 1'b0);
    m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_adr_i = 10'h004; m1_adr_i = 10'h0AA;
    m0_sel_i = 4'hF; m1_sel_i = 4'h3;
    m0_dat_i = 32'hAAAA_0000; m1_dat_i = 32'hBBBB_1111;
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h004};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h004};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0AA};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0AA};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h004};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0AA};

    // Reset state
    do_reset();
    #3;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_s_stb", s_stb_o, 1'b0);
    chk("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
    step();

    // Single master read, slave acks on the 2nd strobe cycle
    set_m(1'b1, 1'b0);
    m0_adr_i = 10'h004;
    #4 chk("rd_idle_gnt", gnt_o, 2'b00);
    step();
    chk("rd_gnt", gnt_o, 2'b01);
    chk("rd_s_cyc", s_cyc_o, 1'b1);
    chk("rd_s_adr", s_adr_o, 10'h004);
    chk("rd_beat1_ack", m0_ack_o, 1'b0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #4;
    chk("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m0_ack", m0_ack_o, 1'b1);
    chk("rd_m1_ack", m1_ack_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    set_m(1'b0, 1'b0);
    step();

    // Cycle-by-cycle table: tie after reset, idle gap, routing, err priority
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_m(tbl[i].m0c, tbl[i].m1c);
      s_ack_i = tbl[i].ack;
      s_err_i = tbl[i].err;
      #4;
      chk($sformatf("tbl%0d_resp", i), {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o},
          {tbl[i].e0a, tbl[i].e0e, tbl[i].e1a, tbl[i].e1e});
      chk($sformatf("tbl%0d_s_cyc", i), s_cyc_o, tbl[i].e_cyc);
      chk($sformatf("tbl%0d_s_adr", i), s_adr_o, tbl[i].e_adr);
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].exp_gnt);
    end

    // Round robin under continuous contention: 0,1,0,1
    do_reset();
    set_m(1'b1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      step();
      chk($sformatf("rr%0d_gnt", t), gnt_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      s_ack_i = 1'b1;
      #4;
      chk($sformatf("rr%0d_acks", t), {m1_ack_o, m0_ack_o}, (t % 2 == 0) ? 2'b01 : 2'b10);
      step();
      s_ack_i = 1'b0;
      if (t % 2 == 0) set_m(1'b0, 1'b1);
      else set_m(1'b1, 1'b0);
      step();
      chk($sformatf("rr%0d_gap", t), gnt_o, 2'b00);
      set_m(1'b1, 1'b1);
    end

    // Timeout: slave never answers, err on the 16th strobe cycle only
    do_reset();
    set_m(1'b1, 1'b0);
    step();
    for (int k = 1; k <= 17; k++) begin
      #4;
      chk($sformatf("tmo%0d_err", k), m0_err_o, (k == 16) ? 1'b1 : 1'b0);
      chk($sformatf("tmo%0d_stb", k), s_stb_o, (k == 16) ? 1'b0 : 1'b1);
      step();
    end
    chk("tmo_s_dat", s_dat_o, 32'hAAAA_0000);
    set_m(1'b0, 1'b0);
    step();

    // Ack arriving in the timeout cycle wins
    set_m(1'b1, 1'b0);
    step();
    chk("ackt_gnt", gnt_o, 2'b01);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) s_ack_i = 1'b1;
      #4;
      chk($sformatf("ackt%0d_err", k), m0_err_o, 1'b0);
      chk($sformatf("ackt%0d_ack", k), m0_ack_o, (k == 16) ? 1'b1 : 1'b0);
      step();
    end
    s_ack_i = 1'b0;
    set_m(1'b0, 1'b0);
    step();

    // Reset while master 1 waits on the slave
    set_m(1'b0, 1'b1);
    step();
    chk("mrst_gnt1", gnt_o, 2'b10);
    repeat (3) step();
    #4 HRESETn = 1'b0;
    #1;
    chk("mrst_gnt", gnt_o, 2'b00);
    chk("mrst_s_cyc", s_cyc_o, 1'b0);
    chk("mrst_s_stb", s_stb_o, 1'b0);
    chk("mrst_m1_resp", {m1_ack_o, m1_err_o}, 2'b00);
    set_m(1'b1, 1'b1);
    step();
    HRESETn = 1'b1;
    step();
    chk("mrst_tie_gnt", gnt_o, 2'b01);
    set_m(1'b0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: slave wait-cycle limit before an error is forced (legal range 2..255).
REQ-002 SHALL have port HCLK, input, 1: clock; all state changes on its rising edge.
REQ-003 SHALL have port HRESETn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports mN_cyc_i, input, 1 (N=0,1): master N bus cycle request.
REQ-005 SHALL have ports mN_stb_i, input, 1: master N strobe.
REQ-006 SHALL have ports mN_we_i, input, 1: master N write enable.
REQ-007 SHALL have ports mN_adr_i, input, [11:2]: master N word address.
REQ-008 SHALL have ports mN_sel_i, input, 4: master N byte selects.
REQ-009 SHALL have ports mN_dat_i, input, 32: master N write data.
REQ-010 SHALL have ports mN_dat_o, output, 32: read data to master N.
REQ-011 SHALL have ports mN_ack_o, output, 1: acknowledge to master N.
REQ-012 SHALL have ports mN_err_o, output, 1: error to master N.
REQ-013 SHALL have ports s_cyc_o, s_stb_o, s_we_o, s_adr_o[11:2], s_sel_o[3:0] and s_dat_o[32], all outputs: shared slave request bus.
REQ-014 SHALL have ports s_dat_i[32], s_ack_i and s_err_i, all inputs: slave response.
REQ-015 SHALL have port gnt_o, output, 2: one-hot current grant (bit N = master N), 00 when idle.

Function
REQ-016 SHALL implement FSM states IDLE, GNT0 and GNT1, held in registers.
REQ-017 SHALL arbitrate only in IDLE: a sole requester (mN_cyc_i=1) is granted; with both requesting, the master not in last_gnt is granted.
REQ-018 SHALL register the grant: cyc asserted in cycle t with the FSM in IDLE gives a GNTN state and s_cyc_o=1 in cycle t+1.
REQ-019 SHALL update the 1-bit last_gnt register to N on every IDLE->GNTN transition.
REQ-020 SHALL, in GNTN, drive all s_* outputs combinationally from master N inputs and drive all s_* outputs to 0 in IDLE.
REQ-021 SHALL broadcast s_dat_i to both mN_dat_o.
REQ-022 SHALL route s_ack_i and s_err_i only to the granted master; the ungranted master sees ack=0 and err=0.
REQ-023 SHALL, when s_ack_i and s_err_i are both 1, present err=1 and ack=0 to the granted master.
REQ-024 SHALL hold a grant while the granted master keeps cyc=1, so multi-beat cycles are never split.
REQ-025 SHALL go GNTN->IDLE on the cycle after mN_cyc_i=0, giving one idle cycle between grants.
REQ-026 SHALL count, in an 8-bit wait counter, cycles in which s_stb_o=1, s_ack_i=0 and s_err_i=0.
REQ-027 SHALL clear the wait counter on ack, on err, when stb=0, and in IDLE.
REQ-028 SHALL, when the wait counter equals TIMEOUT-1 and stb is still unanswered, assert mN_err_o for one cycle.
REQ-029 SHALL, in that same timeout cycle, force s_stb_o=0 and clear the counter.
REQ-030 SHALL, when a slave ack arrives in the same cycle as the timeout, treat the ack as winning and raise no timeout error.
REQ-031 SHALL ignore the ungranted master's stb entirely; it waits and never receives ack.

Reset
REQ-032 SHALL, on HRESETn=0 and regardless of state, set state=IDLE, last_gnt=1 (so master 0 wins the first tie), counter=0 and gnt_o=00.
REQ-033 SHALL hold all s_* outputs and all mN_ack_o and mN_err_o at 0 during reset.
REQ-034 SHALL, on reset assertion mid-transfer, abandon the transfer with no ack or err issued; the master re-requests.

Structure
REQ-035 SHALL take the FSM state encoding and the bus width constants (ADR_MSB=11, ADR_LSB=2, DW=32) from the shared wb_pkg package.
REQ-036 SHALL contain one sub-module, wb_timeout_cnt (the counter plus timeout compare); the rest is flat.

Verification
REQ-037 SHALL be verified for the single master case: m0 requests a read at adr 0x010, slave acks on the 2nd stb cycle with 0xDEADBEEF -> gnt_o=01 one cycle after cyc, m0_dat_o=0xDEADBEEF with m0_ack_o=1, m1_ack_o=0.
REQ-038 SHALL be verified for a tie after reset: m0 and m1 both raise cyc in the same cycle -> m0 is granted first; after m0 drops cyc, IDLE for 1 cycle, then m1 is granted.
REQ-039 SHALL be verified for round-robin under continuous contention: both masters request continuously for 4 transfers -> grant order 0,1,0,1 and last_gnt alternates.
REQ-040 SHALL be verified for timeout: TIMEOUT=16, the slave never acks -> m0_err_o=1 in the 16th stb cycle for exactly 1 cycle, s_stb_o=0 in that cycle.
REQ-041 SHALL be verified for ack and timeout in the same cycle: ack in the 16th stb cycle with TIMEOUT=16 -> ack=1, err=0.
REQ-042 SHALL be verified for reset mid-operation: HRESETn pulled low during a GNT1 wait -> gnt_o=00 and s_cyc_o=0 immediately; after release, m0 wins the first tie.
